// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register: valid/ready handshake with a 2-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt/bubble_cnt statistics counters.
module pipe_stage_skid #(
  parameter int unsigned            PAYLOAD_W = 128,
  parameter logic [PAYLOAD_W-1:0]   NOP_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_abort
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bubble_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]           r_state,      w_state_d;
  logic [PAYLOAD_W-1:0] r_main,       w_main_d;
  logic                 r_main_abort, w_main_abort_d;
  logic [PAYLOAD_W-1:0] r_skid,       w_skid_d;
  logic                 r_skid_abort, w_skid_abort_d;
  logic                 r_in_ready;

  logic w_fire_in;
  logic w_fire_out;

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_payload = r_main;
  assign out_abort   = r_main_abort;

  assign w_fire_in  = in_valid & r_in_ready;
  assign w_fire_out = out_valid & out_ready;

  always_comb begin
    w_state_d      = r_state;
    w_main_d       = r_main;
    w_main_abort_d = r_main_abort;
    w_skid_d       = r_skid;
    w_skid_abort_d = r_skid_abort;
    if (flush) begin
      w_state_d      = ST_EMPTY;
      w_main_d       = NOP_VALUE;
      w_main_abort_d = 1'b0;
      w_skid_d       = NOP_VALUE;
      w_skid_abort_d = 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_fire_in) begin
            w_state_d      = ST_ONE;
            w_main_d       = in_payload;
            w_main_abort_d = in_abort;
          end
        end
        ST_ONE: begin
          if (w_fire_in && w_fire_out) begin
            w_main_d       = in_payload;
            w_main_abort_d = in_abort;
          end else if (w_fire_in) begin
            w_state_d      = ST_TWO;
            w_skid_d       = in_payload;
            w_skid_abort_d = in_abort;
          end else if (w_fire_out) begin
            w_state_d      = ST_EMPTY;
            w_main_d       = NOP_VALUE;
            w_main_abort_d = 1'b0;
          end
        end
        ST_TWO: begin
          if (w_fire_out) begin
            w_state_d      = ST_ONE;
            w_main_d       = r_skid;
            w_main_abort_d = r_skid_abort;
            w_skid_d       = NOP_VALUE;
            w_skid_abort_d = 1'b0;
          end
        end
        default: begin
          w_state_d      = ST_EMPTY;
          w_main_d       = NOP_VALUE;
          w_main_abort_d = 1'b0;
        end
      endcase
    end
  end

  // in_ready is registered from the next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_main       <= NOP_VALUE;
      r_main_abort <= 1'b0;
      r_skid       <= NOP_VALUE;
      r_skid_abort <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_main       <= w_main_d;
      r_main_abort <= w_main_abort_d;
      r_skid       <= w_skid_d;
      r_skid_abort <= w_skid_abort_d;
      r_in_ready   <= (w_state_d != ST_TWO);
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

  // Saturating counters; flush deliberately leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (!out_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (16-bit payload, non-zero NOP value).
// Statistics checks run only when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;

  localparam int unsigned W   = 16;
  localparam logic [W-1:0] NOP = 16'hDEAD;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_payload;
  logic         in_abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_payload;
  logic         out_abort;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  bubble_cnt;
`endif

  int n_chk;
  int n_pass;

  pipe_stage_skid #(
    .PAYLOAD_W (W),
    .NOP_VALUE (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_abort    (in_abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_abort   (out_abort)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] p,
                         input logic a, input logic rdy);
    chk({tag, ".valid"},   {31'd0, out_valid},  {31'd0, v});
    chk({tag, ".payload"}, {16'd0, out_payload}, {16'd0, p});
    chk({tag, ".abort"},   {31'd0, out_abort},  {31'd0, a});
    chk({tag, ".in_ready"}, {31'd0, in_ready},  {31'd0, rdy});
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_payload = '0;
    in_abort   = 1'b0;
    out_ready  = 1'b0;

    // Reset held two cycles
    step();
    step();
    chk_out("reset", 1'b0, NOP, 1'b0, 1'b1);
    rst = 1'b0;

    // Streaming 1..8, one per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_payload = W'(i);
      step();
      chk_out($sformatf("stream%0d", i), 1'b1, W'(i), 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    step();
    chk_out("stream_drain", 1'b0, NOP, 1'b0, 1'b1);

    // Backpressure A,B,C
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 16'h00A1;
    step();
    chk_out("bp_a", 1'b1, 16'h00A1, 1'b0, 1'b1);
    in_payload = 16'h00B2;
    step();
    chk_out("bp_b_skid", 1'b1, 16'h00A1, 1'b0, 1'b0);
    in_payload = 16'h00C3;
    step();
    chk_out("bp_c_held", 1'b1, 16'h00A1, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("bp_out_b", 1'b1, 16'h00B2, 1'b0, 1'b1);
    step();
    chk_out("bp_out_c", 1'b1, 16'h00C3, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    chk_out("bp_empty", 1'b0, NOP, 1'b0, 1'b1);

    // Flush while full with D offered
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 16'h0011;
    step();
    in_payload = 16'h0022;
    step();
    chk_out("fl_full", 1'b1, 16'h0011, 1'b0, 1'b0);
    in_payload = 16'h00DD;
    flush      = 1'b1;
    step();
    chk_out("fl_after", 1'b0, NOP, 1'b0, 1'b1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("fl_no_d", 1'b0, NOP, 1'b0, 1'b1);

    // Flush discards a same-cycle accept from EMPTY
    in_valid   = 1'b1;
    in_payload = 16'h0077;
    flush      = 1'b1;
    step();
    chk_out("fl_fire_in", 1'b0, NOP, 1'b0, 1'b1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_out("fl_fire_in2", 1'b0, NOP, 1'b0, 1'b1);

    // Abort tag travels with payload
    in_valid   = 1'b1;
    in_payload = 16'h0055;
    in_abort   = 1'b1;
    step();
    chk_out("ab_55", 1'b1, 16'h0055, 1'b1, 1'b1);
    in_payload = 16'h0066;
    in_abort   = 1'b0;
    step();
    chk_out("ab_66", 1'b1, 16'h0066, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    chk_out("ab_empty", 1'b0, NOP, 1'b0, 1'b1);

    // Abort tag through the skid entry
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 16'h0031;
    in_abort   = 1'b0;
    step();
    in_payload = 16'h0032;
    in_abort   = 1'b1;
    step();
    chk_out("abs_main", 1'b1, 16'h0031, 1'b0, 1'b0);
    in_valid  = 1'b0;
    in_abort  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("abs_skid", 1'b1, 16'h0032, 1'b1, 1'b1);
    step();
    chk_out("abs_empty", 1'b0, NOP, 1'b0, 1'b1);

`ifdef PIPE_STAGE_STATS_EN
    rst = 1'b1;
    step();
    chk("st_rst_stall",  stall_cnt,  32'd0);
    chk("st_rst_bubble", bubble_cnt, 32'd0);
    rst        = 1'b0;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 16'h0042;
    step();
    chk("st_first_bubble", bubble_cnt, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("st_stall3", stall_cnt, 32'd3);
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("st_stall_hold", stall_cnt,  32'd3);
    chk("st_bubble5",    bubble_cnt, 32'd5);
    // Flush cycle is itself idle, so bubble advances by one but nothing clears
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_flush_stall",  stall_cnt,  32'd3);
    chk("st_flush_bubble", bubble_cnt, 32'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("st_rst2_stall",  stall_cnt,  32'd0);
    chk("st_rst2_bubble", bubble_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
